// File: rtl/ex_bypass_network.sv
// EX-stage operand bypass: EX/MEM, MEM/WB and retired-write history forwarding with load-use stall.
// Optional FWD_STATS_EN adds saturating forward/stall event counters.
module ex_bypass_network #(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 2,
  parameter int HIST_DEPTH = 1
`ifdef FWD_STATS_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*5-1:0]      rs_i,
  input  logic [NUM_SRC*XLEN-1:0]   rf_data_i,
  input  logic                      ex_mem_wr_i,
  input  logic                      ex_mem_load_i,
  input  logic [4:0]                ex_mem_rd_i,
  input  logic [XLEN-1:0]           ex_mem_data_i,
  input  logic                      mem_wb_wr_i,
  input  logic [4:0]                mem_wb_rd_i,
  input  logic [XLEN-1:0]           mem_wb_data_i,
  input  logic                      hist_clr_i,
  output logic [NUM_SRC*XLEN-1:0]   operand_o,
  output logic [NUM_SRC*2-1:0]      fwd_sel_o,
  output logic                      stall_o
`ifdef FWD_STATS_EN
  , output logic [CNT_W-1:0]        fwd_cnt_o
  , output logic [CNT_W-1:0]        stall_cnt_o
`endif
);

  localparam int HD = (HIST_DEPTH > 0) ? HIST_DEPTH : 1;

  logic [HD-1:0]   hv_q;
  logic [4:0]      hrd_q  [HD];
  logic [XLEN-1:0] hdat_q [HD];
  logic            push;

  assign push = mem_wb_wr_i && (mem_wb_rd_i != 5'd0);

  generate
    if (HIST_DEPTH > 0) begin : g_hist
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hv_q <= '0;
        end else if (hist_clr_i) begin
          hv_q <= '0;
        end else if (push) begin
          hv_q[0] <= 1'b1;
          for (int unsigned j = 1; j < HD; j++) hv_q[j] <= hv_q[j-1];
        end
      end

      // Payload needs no reset: it is only observed through the valid bits.
      always_ff @(posedge clk) begin
        if (push && !hist_clr_i) begin
          hrd_q[0]  <= mem_wb_rd_i;
          hdat_q[0] <= mem_wb_data_i;
          for (int unsigned j = 1; j < HD; j++) begin
            hrd_q[j]  <= hrd_q[j-1];
            hdat_q[j] <= hdat_q[j-1];
          end
        end
      end
    end else begin : g_nohist
      assign hv_q      = '0;
      assign hrd_q[0]  = '0;
      assign hdat_q[0] = '0;
    end
  endgenerate

  always_comb begin
    logic [4:0]      rs;
    logic [1:0]      sel;
    logic [XLEN-1:0] op;
    operand_o = '0;
    fwd_sel_o = '0;
    stall_o   = 1'b0;
    rs        = '0;
    sel       = '0;
    op        = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      rs  = rs_i[5*k +: 5];
      sel = 2'b00;
      op  = rf_data_i[XLEN*k +: XLEN];
      if (rs != 5'd0) begin
        // Lowest priority first so later matches override; oldest-to-youngest makes hist[0] win.
        for (int unsigned j = HD; j > 0; j--) begin
          if (hv_q[j-1] && (hrd_q[j-1] == rs)) begin
            sel = 2'b11;
            op  = hdat_q[j-1];
          end
        end
        if (mem_wb_wr_i && (mem_wb_rd_i == rs)) begin
          sel = 2'b01;
          op  = mem_wb_data_i;
        end
        if (ex_mem_wr_i && (ex_mem_rd_i == rs)) begin
          if (ex_mem_load_i) begin
            stall_o = 1'b1;
          end else begin
            sel = 2'b10;
            op  = ex_mem_data_i;
          end
        end
      end
      operand_o[XLEN*k +: XLEN] = op;
      fwd_sel_o[2*k +: 2]       = sel;
    end
  end

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] fwd_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if ((|fwd_sel_o) && (fwd_cnt_q != '1)) fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
      if (stall_o && (stall_cnt_q != '1))    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign fwd_cnt_o   = fwd_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_bypass_network.sv
// Directed bench for ex_bypass_network (NUM_SRC=2, HIST_DEPTH=2); counter checks when FWD_STATS_EN is set.
module tb_ex_bypass_network;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rs_i;
  logic [63:0] rf_data_i;
  logic        ex_mem_wr_i, ex_mem_load_i;
  logic [4:0]  ex_mem_rd_i;
  logic [31:0] ex_mem_data_i;
  logic        mem_wb_wr_i;
  logic [4:0]  mem_wb_rd_i;
  logic [31:0] mem_wb_data_i;
  logic        hist_clr_i;
  logic [63:0] operand_o;
  logic [3:0]  fwd_sel_o;
  logic        stall_o;
`ifdef FWD_STATS_EN
  logic [1:0]  fwd_cnt_o, stall_cnt_o;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ex_bypass_network #(
    .XLEN(32), .NUM_SRC(2), .HIST_DEPTH(2)
`ifdef FWD_STATS_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .rs_i(rs_i), .rf_data_i(rf_data_i),
    .ex_mem_wr_i(ex_mem_wr_i), .ex_mem_load_i(ex_mem_load_i),
    .ex_mem_rd_i(ex_mem_rd_i), .ex_mem_data_i(ex_mem_data_i),
    .mem_wb_wr_i(mem_wb_wr_i), .mem_wb_rd_i(mem_wb_rd_i), .mem_wb_data_i(mem_wb_data_i),
    .hist_clr_i(hist_clr_i), .operand_o(operand_o), .fwd_sel_o(fwd_sel_o), .stall_o(stall_o)
`ifdef FWD_STATS_EN
    , .fwd_cnt_o(fwd_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  typedef struct {
    logic [4:0]  rs0, rs1;
    logic [31:0] rf0, rf1;
    logic        exwr, exld;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        mwwr;
    logic [4:0]  mwrd;
    logic [31:0] mwd;
    logic [31:0] op0, op1;
    logic [1:0]  sel0, sel1;
    logic        stall;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [4:0] r0, input logic [4:0] r1,
                     input logic [31:0] f0, input logic [31:0] f1,
                     input logic ew, input logic el, input logic [4:0] erd, input logic [31:0] ed,
                     input logic mw, input logic [4:0] mrd, input logic [31:0] md);
    rs_i          = {r1, r0};
    rf_data_i     = {f1, f0};
    ex_mem_wr_i   = ew;
    ex_mem_load_i = el;
    ex_mem_rd_i   = erd;
    ex_mem_data_i = ed;
    mem_wb_wr_i   = mw;
    mem_wb_rd_i   = mrd;
    mem_wb_data_i = md;
  endtask

  initial begin
    //          rs0 rs1 rf0      rf1      ew el erd ed         mw mrd md       op0      op1      s0 s1 st
    vecs[0] = '{0,  0,  32'h1234,32'h5678,0, 0, 0,  32'h0,     0, 0,  32'h0,   32'h1234,32'h5678,0, 0, 0};
    vecs[1] = '{5,  9,  32'h50,  32'h99,  1, 0, 5,  32'hAAAA,  1, 5,  32'hBBBB,32'hAAAA,32'h99,  2, 0, 0};
    vecs[2] = '{2,  7,  32'h22,  32'h70,  1, 1, 7,  32'hDEAD,  1, 7,  32'h11,  32'h22,  32'h11,  0, 1, 1};
    vecs[3] = '{0,  0,  32'h0,   32'h3,   1, 0, 0,  32'hFFFF,  1, 0,  32'h7,   32'h0,   32'h3,   0, 0, 0};
    vecs[4] = '{4,  4,  32'h40,  32'h41,  1, 0, 3,  32'h33,    1, 4,  32'h44,  32'h44,  32'h44,  1, 1, 0};
    vecs[5] = '{8,  1,  32'h80,  32'h10,  1, 1, 8,  32'hDEAD,  0, 8,  32'h77,  32'h80,  32'h10,  0, 0, 1};
    vecs[6] = '{6,  6,  32'h60,  32'h61,  0, 0, 6,  32'h66,    0, 6,  32'h67,  32'h60,  32'h61,  0, 0, 0};
    vecs[7] = '{0,  0,  32'h0,   32'h0,   1, 1, 0,  32'h0,     0, 0,  32'h0,   32'h0,   32'h0,   0, 0, 0};
    vecs[8] = '{10, 11, 32'h1,   32'h2,   1, 0, 10, 32'hA0,    1, 11, 32'hB0,  32'hA0,  32'hB0,  2, 1, 0};
    vecs[9] = '{31, 31, 32'h5,   32'h6,   1, 1, 31, 32'hEE,    1, 31, 32'h1F,  32'h1F,  32'h1F,  1, 1, 1};

    drv(0, 0, 32'h1234, 32'h5678, 0, 0, 0, 0, 0, 0, 0);
    hist_clr_i = 1'b0;
    rst_n      = 1'b0;
    #2;
    chk("reset_operand", operand_o, {32'h5678, 32'h1234});
    chk("reset_sel", {60'd0, fwd_sel_o}, 64'd0);
    chk("reset_stall", {63'd0, stall_o}, 64'd0);
`ifdef FWD_STATS_EN
    chk("reset_cnt", {60'd0, fwd_cnt_o, stall_cnt_o}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // History held empty during the table so only pipe sources matter.
    hist_clr_i = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      drv(vecs[i].rs0, vecs[i].rs1, vecs[i].rf0, vecs[i].rf1, vecs[i].exwr, vecs[i].exld,
          vecs[i].exrd, vecs[i].exd, vecs[i].mwwr, vecs[i].mwrd, vecs[i].mwd);
      #2;
      chk($sformatf("vec%0d_operand", i), operand_o, {vecs[i].op1, vecs[i].op0});
      chk($sformatf("vec%0d_sel", i), {60'd0, fwd_sel_o}, {60'd0, vecs[i].sel1, vecs[i].sel0});
      chk($sformatf("vec%0d_stall", i), {63'd0, stall_o}, {63'd0, vecs[i].stall});
    end

    // History: two retires of rd=3, youngest wins.
    @(negedge clk);
    hist_clr_i = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h30);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h31);
    @(negedge clk);
    drv(3, 3, 32'h3, 32'h4, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("hist_young_op", operand_o, {32'h31, 32'h31});
    chk("hist_young_sel", {60'd0, fwd_sel_o}, 64'hF);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h90);
    @(negedge clk);
    drv(3, 0, 32'h3, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("hist_entry1_op", operand_o[31:0], {32'h0, 32'h31});
    chk("hist_entry1_sel", {60'd0, fwd_sel_o}, 64'h3);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hC0);
    @(negedge clk);
    drv(3, 9, 32'h3, 32'h9, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("hist_drop_op", operand_o, {32'h90, 32'h3});
    chk("hist_drop_sel", {60'd0, fwd_sel_o}, 64'hC);
    @(negedge clk);
    drv(9, 0, 32'h9, 0, 0, 0, 0, 0, 1, 9, 32'h91);
    #2;
    chk("mw_over_hist", {28'd0, fwd_sel_o, operand_o[31:0]}, {28'd0, 4'h1, 32'h91});
    @(negedge clk);
    drv(9, 12, 32'h9, 32'hC, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("hist_dup_rd", operand_o, {32'hC0, 32'h91});

    // Clear wins over a simultaneous push, and flushes older entries.
    @(negedge clk);
    hist_clr_i = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h44);
    @(negedge clk);
    hist_clr_i = 1'b0;
    drv(4, 9, 32'h99, 32'h5, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("clr_push_op", operand_o, {32'h5, 32'h99});
    chk("clr_push_sel", {60'd0, fwd_sel_o}, 64'd0);

    // Asynchronous reset mid-run discards history.
    @(negedge clk);
    drv(0, 0, 0, 0, 1, 0, 5, 32'h5, 1, 6, 32'h66);
    @(negedge clk);
    drv(6, 0, 32'h5, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("pre_reset_hist", {28'd0, fwd_sel_o, operand_o[31:0]}, {28'd0, 4'h3, 32'h66});
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_op", {28'd0, fwd_sel_o, operand_o[31:0]}, {28'd0, 4'h0, 32'h5});
`ifdef FWD_STATS_EN
    chk("async_reset_cnt", {60'd0, fwd_cnt_o, stall_cnt_o}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

`ifdef FWD_STATS_EN
    drv(5, 0, 0, 0, 1, 0, 5, 32'h1, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("fwd_cnt_sat", {62'd0, fwd_cnt_o}, 64'd3);
    chk("stall_cnt_idle", {62'd0, stall_cnt_o}, 64'd0);
    drv(5, 0, 0, 0, 1, 1, 5, 32'h1, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("stall_cnt_two", {62'd0, stall_cnt_o}, 64'd2);
    hist_clr_i = 1'b1;
    @(negedge clk);
    hist_clr_i = 1'b0;
    chk("stall_cnt_sat_clr", {60'd0, fwd_cnt_o, stall_cnt_o}, {60'd0, 2'd3, 2'd3});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
